// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop,
// operands consumed LSB-first, one bit per clock.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit, c_bit, last;

  assign s_bit = sh_a[0] ^ sh_b[0] ^ carry;
  assign c_bit = (sh_a[0] & sh_b[0]) |
                 (carry & (sh_a[0] ^ sh_b[0]));
  assign last  = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      sh_a  <= a;
      sh_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
      res   <= {s_bit, res[WIDTH-1:1]};
      carry <= c_bit;
      cnt   <= cnt + CW'(1);
      // carry register here is the carry into the MSB slice
      if (last) begin
        sum  <= {s_bit, res[WIDTH-1:1]};
        cout <= c_bit;
        ovf  <= carry ^ c_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: WIDTH=8 directed/random plus
// WIDTH=3 exhaustive back-to-back run.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start3, sub3, busy3, done3, cout3, ovf3;
  logic [2:0] a3, b3, sum3;

  serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .sub(sub3),
    .a(a3), .b(b3), .busy(busy3), .done(done3),
    .sum(sum3), .cout(cout3), .ovf(ovf3)
  );

  typedef struct {
    int s;
    bit c;
    bit o;
  } res_t;

  res_t q8[$];
  res_t q3[$];
  int   tests = 0;
  int   fails = 0;
  int   hold8 = 0;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  // Reference: modular sum/carry plus signed range check
  function automatic res_t model(int w, int a, int b, bit s);
    res_t r;
    int   mask, bb, t, sa, sb, v;
    mask = (1 << w) - 1;
    bb   = s ? (~b & mask) : b;
    t    = a + bb + int'(s);
    r.s  = t & mask;
    r.c  = ((t >> w) & 1) != 0;
    sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    v    = s ? sa - sb : sa + sb;
    r.o  = (v < -(1 << (w - 1))) || (v > (1 << (w - 1)) - 1);
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (done8 === 1'b1) begin
      chk("done8_expected", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("sum8", 32'(sum8), e.s);
        chk("cout8", 32'(cout8), 32'(e.c));
        chk("ovf8", 32'(ovf8), 32'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (done3 === 1'b1) begin
      chk("done3_expected", 32'(q3.size() != 0), 1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("sum3", 32'(sum3), e.s);
        chk("cout3", 32'(cout3), 32'(e.c));
        chk("ovf3", 32'(ovf3), 32'(e.o));
      end
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input bit s, input bit poke);
    res_t e;
    e = model(8, int'(a), int'(b), s);
    a8 = a;
    b8 = b;
    sub8 = s;
    start8 = 1'b1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    sub8 = 1'($urandom);
    for (int j = 0; j <= 9; j++) begin
      chk("busy8_timing", 32'(busy8), 32'(j < 8));
      chk("done8_timing", 32'(done8), 32'(j == 8));
      if (j < 8) chk("sum8_hold", 32'(sum8), hold8);
      if (poke && j == 3) begin
        start8 = 1'b1;
        a8 = ~a;
        b8 = b + 8'd3;
      end
      if (poke && j == 4) start8 = 1'b0;
      @(negedge clk);
    end
    hold8 = e.s;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    start3 = 0; sub3 = 0; a3 = 0; b3 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'({busy8, busy3}), 0);
    chk("rst_done", 32'({done8, done3}), 0);
    chk("rst_sum", 32'({sum8, sum3}), 0);
    chk("rst_flags", 32'({cout8, ovf8, cout3, ovf3}), 0);
    rst = 1'b0;
    @(negedge clk);

    run8(8'h0F, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h80, 8'h80, 1'b0, 1'b1);
    run8(8'h05, 8'h07, 1'b1, 1'b0);
    run8(8'h80, 8'h01, 1'b1, 1'b1);
    run8(8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    a8 = 8'h33;
    b8 = 8'h44;
    sub8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy8), 0);
    chk("midrst_done", 32'(done8), 0);
    chk("midrst_sum", 32'(sum8), 0);
    chk("midrst_flags", 32'({cout8, ovf8}), 0);
    @(negedge clk);
    rst = 1'b0;
    hold8 = 0;
    repeat (12) begin
      @(negedge clk);
      chk("midrst_nodone", 32'(done8), 0);
    end
    run8(8'h12, 8'hF0, 1'b1, 1'b0);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++) begin
          a3 = 3'(a);
          b3 = 3'(b);
          sub3 = 1'(s);
          start3 = 1'b1;
          q3.push_back(model(3, a, b, 1'(s)));
          repeat (5) @(negedge clk);
        end
    start3 = 1'b0;
    repeat (10) @(negedge clk);

    chk("q8_drained", q8.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
